// File: rtl/parking_ctrl_pkg.sv
// Shared FSM encodings and width helpers for the parking-lot entry controller.
// Imported by the controller top and its interval timer.
package parking_ctrl_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_PASS = 2'd1;
  localparam logic [1:0] GRANT     = 2'd2;
  localparam logic [1:0] LOCKED    = 2'd3;

  function automatic int max3(input int a,
                              input int b,
                              input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Width of a down-counter able to hold the longest interval.
  function automatic int tw_of(input int a,
                               input int b,
                               input int c);
    return $clog2(max3(a, b, c) + 1);
  endfunction

endpackage

// File: rtl/parking_ctrl_if.sv
// Sensor/keypad/gate bundle of the parking controller.
// master: drives sensors and keypad; slave: the controller.
interface parking_ctrl_if #(
  parameter int PW = 4,
  parameter int CW = 4
);

  logic          entry_sensor;
  logic          exit_pulse;
  logic [PW-1:0] pass;
  logic          pass_valid;
  logic          gate_open;
  logic          alarm;
  logic          full;
  logic [CW-1:0] occupancy;

  modport master (
    output entry_sensor,
    output exit_pulse,
    output pass,
    output pass_valid,
    input  gate_open,
    input  alarm,
    input  full,
    input  occupancy
  );

  modport slave (
    input  entry_sensor,
    input  exit_pulse,
    input  pass,
    input  pass_valid,
    output gate_open,
    output alarm,
    output full,
    output occupancy
  );

endinterface

// File: rtl/parking_ctrl_timer.sv
// Loadable down-counter shared by the timeout, gate and lockout intervals.
// Ports: clk, reset, load, value (load value), done (count reached 1).
module parking_ctrl_timer #(
  parameter int TW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] value,
  output logic          done
);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - TW'(1);
    end
  end

  // Intervals are loaded with N and end on the Nth cycle.
  assign done = (count == TW'(1));

endmodule

// File: rtl/parking_ctrl.sv
// Parking-lot entry controller: passcode gate, lockout alarm, occupancy.
// Ports: clk, reset (sync, active-high), bus (parking_ctrl_if.slave).
module parking_ctrl
  import parking_ctrl_pkg::*;
#(
  parameter int            PW          = 4,
  parameter logic [PW-1:0] PASSCODE    = 4'b1101,
  parameter int            CAPACITY    = 8,
  parameter int            MAX_TRIES   = 3,
  parameter int            TIMEOUT     = 16,
  parameter int            GATE_CYCLES = 4,
  parameter int            LOCK_CYCLES = 32
) (
  input  logic           clk,
  input  logic           reset,
  parking_ctrl_if.slave  bus
);

  localparam int CW  = $clog2(CAPACITY + 1);
  localparam int TW  = tw_of(TIMEOUT, GATE_CYCLES, LOCK_CYCLES);
  localparam int TRW = $clog2(MAX_TRIES + 1);

  logic [1:0]     state;
  logic [1:0]     state_d;
  logic [TRW-1:0] tries;
  logic [TRW-1:0] tries_d;
  logic [TRW-1:0] tries_inc;
  logic [CW-1:0]  occ;
  logic           full;
  logic           match;
  logic           inc;
  logic           dec;
  logic           t_load;
  logic [TW-1:0]  t_val;
  logic           t_done;
  logic           gate_r;
  logic           alarm_r;

  parking_ctrl_timer #(
    .TW(TW)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (t_load),
    .value (t_val),
    .done  (t_done)
  );

  assign full      = (occ == CW'(CAPACITY));
  assign match     = (bus.pass == PASSCODE);
  assign tries_inc = tries + TRW'(1);
  // An exit with an empty lot is a sensor glitch.
  assign dec       = bus.exit_pulse && (occ != '0);

  always_comb begin
    state_d = state;
    tries_d = tries;
    t_load  = 1'b0;
    t_val   = '0;
    inc     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.entry_sensor && !full) begin
          state_d = WAIT_PASS;
          tries_d = '0;
          t_load  = 1'b1;
          t_val   = TW'(TIMEOUT);
        end
      end
      WAIT_PASS: begin
        if (!bus.entry_sensor) begin
          state_d = IDLE;
        end else if (bus.pass_valid && match && !full) begin
          state_d = GRANT;
          inc     = 1'b1;
          t_load  = 1'b1;
          t_val   = TW'(GATE_CYCLES);
        end else if (bus.pass_valid && match) begin
          state_d = IDLE;
        end else if (bus.pass_valid) begin
          tries_d = tries_inc;
          t_load  = 1'b1;
          if (tries_inc == TRW'(MAX_TRIES)) begin
            state_d = LOCKED;
            t_val   = TW'(LOCK_CYCLES);
          end else begin
            t_val   = TW'(TIMEOUT);
          end
        end else if (t_done) begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (t_done) state_d = IDLE;
      end
      LOCKED: begin
        if (t_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tries   <= '0;
      gate_r  <= 1'b0;
      alarm_r <= 1'b0;
    end else begin
      state   <= state_d;
      tries   <= tries_d;
      gate_r  <= (state_d == GRANT);
      alarm_r <= (state_d == LOCKED);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ <= '0;
    end else if (inc && !dec) begin
      occ <= occ + CW'(1);
    end else if (dec && !inc) begin
      occ <= occ - CW'(1);
    end
  end

  assign bus.gate_open = gate_r;
  assign bus.alarm     = alarm_r;
  assign bus.full      = full;
  assign bus.occupancy = occ;

endmodule

// File: tb/tb_parking_ctrl.sv
// Self-checking bench for parking_ctrl: vector table plus
// hand-written lockout, capacity, timeout and reset sequences.
module tb_parking_ctrl;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  parking_ctrl_if #(.PW(4), .CW(4)) bus ();

  parking_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ent;
    logic       ext;
    logic       pv;
    logic [3:0] pass;
    logic [6:0] exp;
  } vec_t;

  vec_t q[$];

  localparam logic [3:0] OK  = 4'b1101;
  localparam logic [3:0] BAD = 4'b0000;

  task automatic v(input logic rst, input logic ent,
                   input logic ext, input logic pv,
                   input logic [3:0] pass, input logic gate,
                   input logic [3:0] occ);
    vec_t r;
    r.rst  = rst;
    r.ent  = ent;
    r.ext  = ext;
    r.pv   = pv;
    r.pass = pass;
    r.exp  = {gate, 1'b0, 1'b0, occ};
    q.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [6:0] obs();
    return {bus.gate_open, bus.alarm, bus.full, bus.occupancy};
  endfunction

  task automatic drive(input logic ent, input logic ext,
                       input logic pv, input logic [3:0] pass);
    bus.entry_sensor = ent;
    bus.exit_pulse   = ext;
    bus.pass_valid   = pv;
    bus.pass         = pass;
  endtask

  task automatic grant_car();
    drive(1, 0, 0, BAD);
    step();
    drive(1, 0, 1, OK);
    step();
    drive(0, 0, 0, BAD);
    repeat (5) step();
  endtask

  int alarm_cnt;
  int gate_seen;

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    drive(0, 0, 0, BAD);

    // reset
    v(1, 0, 0, 0, BAD, 0, 0);
    // single grant: gate high 4 cycles, occupancy 0->1
    v(0, 1, 0, 0, BAD, 0, 0);
    v(0, 1, 0, 1, OK,  1, 1);
    v(0, 0, 0, 0, BAD, 1, 1);
    v(0, 0, 0, 0, BAD, 1, 1);
    v(0, 0, 0, 0, BAD, 1, 1);
    v(0, 0, 0, 0, BAD, 0, 1);
    // two wrong codes then the right one
    v(0, 1, 0, 0, BAD, 0, 1);
    v(0, 1, 0, 1, BAD, 0, 1);
    v(0, 1, 0, 1, BAD, 0, 1);
    v(0, 1, 0, 1, OK,  1, 2);
    v(0, 0, 0, 0, BAD, 1, 2);
    v(0, 0, 0, 0, BAD, 1, 2);
    v(0, 0, 0, 0, BAD, 1, 2);
    v(0, 0, 0, 0, BAD, 0, 2);
    // reach occupancy 3
    v(0, 1, 0, 0, BAD, 0, 2);
    v(0, 1, 0, 1, OK,  1, 3);
    v(0, 0, 0, 0, BAD, 1, 3);
    v(0, 0, 0, 0, BAD, 1, 3);
    v(0, 0, 0, 0, BAD, 1, 3);
    v(0, 0, 0, 0, BAD, 0, 3);
    // grant and exit in the same cycle: occupancy stays 3
    v(0, 1, 0, 0, BAD, 0, 3);
    v(0, 1, 1, 1, OK,  1, 3);
    v(0, 0, 0, 0, BAD, 1, 3);
    v(0, 0, 0, 0, BAD, 1, 3);
    v(0, 0, 0, 0, BAD, 1, 3);
    v(0, 0, 0, 0, BAD, 0, 3);
    // drain, then exit at zero saturates
    v(0, 0, 1, 0, BAD, 0, 2);
    v(0, 0, 1, 0, BAD, 0, 1);
    v(0, 0, 1, 0, BAD, 0, 0);
    v(0, 0, 1, 0, BAD, 0, 0);
    // car leaves with a valid code pending: no grant
    v(0, 1, 0, 0, BAD, 0, 0);
    v(0, 0, 0, 1, OK,  0, 0);
    v(0, 0, 0, 0, BAD, 0, 0);

    foreach (q[i]) begin
      reset = q[i].rst;
      drive(q[i].ent, q[i].ext, q[i].pv, q[i].pass);
      step();
      check($sformatf("vec%0d", i), 32'(obs()), 32'(q[i].exp));
    end
    reset = 1'b0;
    drive(0, 0, 0, BAD);

    // lockout after three wrong codes
    drive(1, 0, 0, BAD);
    step();
    drive(1, 0, 1, BAD);
    step();
    check("lock_try1", 32'(bus.alarm), 0);
    step();
    check("lock_try2", 32'(bus.alarm), 0);
    step();
    check("lock_try3", 32'(bus.alarm), 1);
    alarm_cnt = 1;
    gate_seen = 0;
    drive(0, 0, 1, OK);
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.alarm) alarm_cnt++;
      if (bus.gate_open) gate_seen++;
    end
    check("lock_len", 32'(alarm_cnt), 32);
    check("lock_nogate", 32'(gate_seen), 0);
    check("lock_occ", 32'(bus.occupancy), 0);
    check("lock_end", 32'(bus.alarm), 0);
    drive(0, 0, 0, BAD);
    step();

    // fill to capacity
    for (int i = 0; i < 8; i++) grant_car();
    check("fill_occ", 32'(bus.occupancy), 8);
    check("fill_full", 32'(bus.full), 1);
    drive(1, 0, 0, BAD);
    step();
    step();
    drive(1, 0, 1, OK);
    step();
    check("full_refuse", 32'(obs()), 32'({1'b0, 1'b0, 1'b1, 4'd8}));
    drive(1, 1, 0, BAD);
    step();
    check("full_exit", 32'(obs()), 32'({1'b0, 1'b0, 1'b0, 4'd7}));
    drive(1, 0, 0, BAD);
    step();
    drive(1, 0, 1, OK);
    step();
    check("full_regrant", 32'(obs()), 32'({1'b1, 1'b0, 1'b1, 4'd8}));
    drive(0, 0, 0, BAD);
    repeat (5) step();

    // timeout: strobe on 16th WAIT cycle is still accepted
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_occ", 32'(bus.occupancy), 0);
    drive(1, 0, 0, BAD);
    step();
    repeat (16) step();
    drive(1, 0, 1, OK);
    step();
    check("to_expired", 32'(bus.gate_open), 0);
    drive(0, 0, 0, BAD);
    step();
    drive(1, 0, 0, BAD);
    step();
    repeat (15) step();
    drive(1, 0, 1, OK);
    step();
    check("to_last", 32'(obs()), 32'({1'b1, 1'b0, 1'b0, 4'd1}));

    // reset during GRANT
    drive(0, 0, 0, BAD);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_grant", 32'(obs()), 0);
    step();
    check("rst_after", 32'(obs()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
